io_alu_sequencer: RTL and testbench

//  Hard-wired control sequencer for the CPU datapath. Steps the fetch cycle
//  (T0-T2), decodes IR[31:27], and drives the one-hot datapath strobes for
//  in, out, add, sub, and, or, nop and halt.

---
 rtl/io_alu_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_io_alu_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_alu_sequencer.sv
// io_alu_sequencer: hard-wired control sequencer for the CPU datapath.
// Steps the fetch cycle (T0-T2), decodes the opcode in i_ir[31:27] and drives
// one-hot datapath strobes for in, out, add, sub, and, or, nop and halt.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset (clear)
//   i_ir           instruction register contents, valid from T3
//   i_stop         pause request, honoured only at an instruction boundary
//   o_pc_out..     datapath, memory, register-select, ALU and I/O strobes
//   o_run          1 while executing T0-T5
//   o_illegal      sticky flag, set when an undefined opcode reaches T3
module io_alu_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ir,
  input  logic        i_stop,
  output logic        o_pc_out,
  output logic        o_mar_in,
  output logic        o_inc_pc,
  output logic        o_zlow_in,
  output logic        o_zlow_out,
  output logic        o_pc_in,
  output logic        o_read,
  output logic        o_md_read,
  output logic        o_mdr_in,
  output logic        o_mdr_out,
  output logic        o_ir_in,
  output logic        o_gra,
  output logic        o_grb,
  output logic        o_grc,
  output logic        o_r_in,
  output logic        o_r_out,
  output logic        o_ba_out,
  output logic        o_y_in,
  output logic        o_add,
  output logic        o_sub,
  output logic        o_and,
  output logic        o_or,
  output logic        o_in_port_out,
  output logic        o_out_port_in,
  output logic        o_run,
  output logic        o_illegal
);

  localparam int unsigned OpcW = 5;
  localparam logic [OpcW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpcW-1:0] OpOr   = 5'b00110;
  localparam logic [OpcW-1:0] OpIn   = 5'b10110;
  localparam logic [OpcW-1:0] OpOut  = 5'b10111;
  localparam logic [OpcW-1:0] OpNop  = 5'b11010;
  localparam logic [OpcW-1:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StPause, StHalt
  } state_e;

  state_e          r_state;
  logic            r_illegal;
  logic [OpcW-1:0] w_opc;
  state_e          w_end_state;
  logic            w_unused_ir;

  assign w_opc       = i_ir[31:27];
  assign w_unused_ir = ^i_ir[26:0];
  // Instruction boundary: Stop is sampled on the same edge that leaves the last step.
  assign w_end_state = i_stop ? StPause : StT0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        StIdle: r_state <= w_end_state;
        StT0:   r_state <= StT1;
        StT1:   r_state <= StT2;
        StT2:   r_state <= StT3;
        StT3: begin
          case (w_opc)
            OpAdd, OpSub, OpAnd, OpOr: r_state <= StT4;
            OpHalt:                    r_state <= StHalt;
            OpIn, OpOut, OpNop:        r_state <= w_end_state;
            default: begin
              // Undefined opcode executes as nop but leaves a sticky flag.
              r_state   <= w_end_state;
              r_illegal <= 1'b1;
            end
          endcase
        end
        StT4:    r_state <= StT5;
        StT5:    r_state <= w_end_state;
        StPause: r_state <= i_stop ? StPause : StT0;
        StHalt:  r_state <= StHalt;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Opcode only reaches the outputs in T3/T4, so IR changes elsewhere cannot glitch them.
  always_comb begin
    o_pc_out      = 1'b0;
    o_mar_in      = 1'b0;
    o_inc_pc      = 1'b0;
    o_zlow_in     = 1'b0;
    o_zlow_out    = 1'b0;
    o_pc_in       = 1'b0;
    o_read        = 1'b0;
    o_md_read     = 1'b0;
    o_mdr_in      = 1'b0;
    o_mdr_out     = 1'b0;
    o_ir_in       = 1'b0;
    o_gra         = 1'b0;
    o_grb         = 1'b0;
    o_grc         = 1'b0;
    o_r_in        = 1'b0;
    o_r_out       = 1'b0;
    o_ba_out      = 1'b0;
    o_y_in        = 1'b0;
    o_add         = 1'b0;
    o_sub         = 1'b0;
    o_and         = 1'b0;
    o_or          = 1'b0;
    o_in_port_out = 1'b0;
    o_out_port_in = 1'b0;
    o_run         = 1'b0;
    case (r_state)
      StT0: begin
        o_run     = 1'b1;
        o_pc_out  = 1'b1;
        o_mar_in  = 1'b1;
        o_inc_pc  = 1'b1;
        o_zlow_in = 1'b1;
      end
      StT1: begin
        o_run      = 1'b1;
        o_zlow_out = 1'b1;
        o_pc_in    = 1'b1;
        o_read     = 1'b1;
        o_md_read  = 1'b1;
        o_mdr_in   = 1'b1;
      end
      StT2: begin
        o_run     = 1'b1;
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
      end
      StT3: begin
        o_run = 1'b1;
        case (w_opc)
          OpIn: begin
            o_gra         = 1'b1;
            o_r_in        = 1'b1;
            o_in_port_out = 1'b1;
          end
          OpOut: begin
            o_gra         = 1'b1;
            o_r_out       = 1'b1;
            o_out_port_in = 1'b1;
          end
          OpAdd, OpSub, OpAnd, OpOr: begin
            o_grb   = 1'b1;
            o_r_out = 1'b1;
            o_y_in  = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        o_run     = 1'b1;
        o_grc     = 1'b1;
        o_r_out   = 1'b1;
        o_zlow_in = 1'b1;
        o_add     = (w_opc == OpAdd);
        o_sub     = (w_opc == OpSub);
        o_and     = (w_opc == OpAnd);
        o_or      = (w_opc == OpOr);
      end
      StT5: begin
        o_run      = 1'b1;
        o_zlow_out = 1'b1;
        o_gra      = 1'b1;
        o_r_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_illegal = r_illegal;

  // At most one bus driver per cycle.
  a_single_bus_driver : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0({o_pc_out, o_zlow_out, o_mdr_out, o_r_out, o_in_port_out}));

endmodule

// File: tb/tb_io_alu_sequencer.sv
// Randomized bench for io_alu_sequencer with a per-instruction step-list model.
module tb_io_alu_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_ir;
  logic        i_stop;
  logic o_pc_out, o_mar_in, o_inc_pc, o_zlow_in, o_zlow_out, o_pc_in;
  logic o_read, o_md_read, o_mdr_in, o_mdr_out, o_ir_in;
  logic o_gra, o_grb, o_grc, o_r_in, o_r_out, o_ba_out, o_y_in;
  logic o_add, o_sub, o_and, o_or, o_in_port_out, o_out_port_in;
  logic o_run, o_illegal;

  io_alu_sequencer dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ir          (i_ir),
    .i_stop        (i_stop),
    .o_pc_out      (o_pc_out),
    .o_mar_in      (o_mar_in),
    .o_inc_pc      (o_inc_pc),
    .o_zlow_in     (o_zlow_in),
    .o_zlow_out    (o_zlow_out),
    .o_pc_in       (o_pc_in),
    .o_read        (o_read),
    .o_md_read     (o_md_read),
    .o_mdr_in      (o_mdr_in),
    .o_mdr_out     (o_mdr_out),
    .o_ir_in       (o_ir_in),
    .o_gra         (o_gra),
    .o_grb         (o_grb),
    .o_grc         (o_grc),
    .o_r_in        (o_r_in),
    .o_r_out       (o_r_out),
    .o_ba_out      (o_ba_out),
    .o_y_in        (o_y_in),
    .o_add         (o_add),
    .o_sub         (o_sub),
    .o_and         (o_and),
    .o_or          (o_or),
    .o_in_port_out (o_in_port_out),
    .o_out_port_in (o_out_port_in),
    .o_run         (o_run),
    .o_illegal     (o_illegal)
  );

  logic [23:0] w_obs;
  assign w_obs = {o_out_port_in, o_in_port_out, o_or, o_and, o_sub, o_add, o_y_in, o_ba_out,
                  o_r_out, o_r_in, o_grc, o_grb, o_gra, o_ir_in, o_mdr_out, o_mdr_in,
                  o_md_read, o_read, o_pc_in, o_zlow_out, o_zlow_in, o_inc_pc, o_mar_in,
                  o_pc_out};

  localparam logic [23:0] SPcOut     = 24'h000001;
  localparam logic [23:0] SMarIn     = 24'h000002;
  localparam logic [23:0] SIncPc     = 24'h000004;
  localparam logic [23:0] SZlowIn    = 24'h000008;
  localparam logic [23:0] SZlowOut   = 24'h000010;
  localparam logic [23:0] SPcIn      = 24'h000020;
  localparam logic [23:0] SRead      = 24'h000040;
  localparam logic [23:0] SMdRead    = 24'h000080;
  localparam logic [23:0] SMdrIn     = 24'h000100;
  localparam logic [23:0] SMdrOut    = 24'h000200;
  localparam logic [23:0] SIrIn      = 24'h000400;
  localparam logic [23:0] SGra       = 24'h000800;
  localparam logic [23:0] SGrb       = 24'h001000;
  localparam logic [23:0] SGrc       = 24'h002000;
  localparam logic [23:0] SRin       = 24'h004000;
  localparam logic [23:0] SRout      = 24'h008000;
  localparam logic [23:0] SYin       = 24'h020000;
  localparam logic [23:0] SAdd       = 24'h040000;
  localparam logic [23:0] SSub       = 24'h080000;
  localparam logic [23:0] SAnd       = 24'h100000;
  localparam logic [23:0] SOr        = 24'h200000;
  localparam logic [23:0] SInPortOut = 24'h400000;
  localparam logic [23:0] SOutPortIn = 24'h800000;

  localparam int MIdle = 0, MRun = 1, MPause = 2, MHalt = 3;

  int          n_checks;
  int          n_errors;
  int          m_mode;
  logic [23:0] m_q[$];
  logic [31:0] forced_ir[$];
  bit          m_alu, m_halt_end, m_ill_end, m_illegal;
  bit          ir_pending, did_mid_reset;
  logic [31:0] next_ir;
  int          halt_cnt;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_ir();
    logic [4:0] op;
    int         r;
    r = int'($urandom_range(0, 15));
    case (r)
      0, 1:    op = 5'b10110;
      2, 3:    op = 5'b10111;
      4, 5:    op = 5'b00011;
      6, 7:    op = 5'b00100;
      8, 9:    op = 5'b00101;
      10, 11:  op = 5'b00110;
      12:      op = 5'b11010;
      13:      op = 5'b11011;
      default: op = 5'($urandom_range(0, 31));
    endcase
    return {op, 27'($urandom)};
  endfunction

  // Builds the full list of per-cycle strobe words for one instruction.
  task automatic start_instr();
    logic [31:0] ir;
    logic [4:0]  op;
    ir = (forced_ir.size() > 0) ? forced_ir.pop_front() : pick_ir();
    op = ir[31:27];
    m_q.delete();
    m_alu      = 1'b0;
    m_halt_end = 1'b0;
    m_ill_end  = 1'b0;
    m_q.push_back(SPcOut | SMarIn | SIncPc | SZlowIn);
    m_q.push_back(SZlowOut | SPcIn | SRead | SMdRead | SMdrIn);
    m_q.push_back(SMdrOut | SIrIn);
    case (op)
      5'b10110: m_q.push_back(SGra | SRin | SInPortOut);
      5'b10111: m_q.push_back(SGra | SRout | SOutPortIn);
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        m_alu = 1'b1;
        m_q.push_back(SGrb | SRout | SYin);
        m_q.push_back(SGrc | SRout | SZlowIn |
                      ((op == 5'b00011) ? SAdd : (op == 5'b00100) ? SSub :
                       (op == 5'b00101) ? SAnd : SOr));
        m_q.push_back(SZlowOut | SGra | SRin);
      end
      5'b11010: m_q.push_back(24'h0);
      5'b11011: begin
        m_q.push_back(24'h0);
        m_halt_end = 1'b1;
      end
      default: begin
        m_q.push_back(24'h0);
        m_ill_end = 1'b1;
      end
    endcase
    m_mode     = MRun;
    next_ir    = ir;
    ir_pending = 1'b1;
  endtask

  task automatic advance_model();
    case (m_mode)
      MIdle:  if (i_stop) m_mode = MPause; else start_instr();
      MPause: if (!i_stop) start_instr();
      MRun: begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          if (m_ill_end) m_illegal = 1'b1;
          if (m_halt_end) m_mode = MHalt;
          else if (i_stop) m_mode = MPause;
          else start_instr();
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_cycle();
    logic [23:0] exp_s;
    exp_s = (m_mode == MRun) ? m_q[0] : 24'h0;
    check_eq("strobes", 32'(w_obs), 32'(exp_s));
    check_eq("run", 32'(o_run), 32'(m_mode == MRun));
    check_eq("illegal", 32'(o_illegal), 32'(m_illegal));
    if (m_mode == MHalt) halt_cnt++;
  endtask

  // Asserted mid-cycle at a negedge so the async path is exercised; released a cycle later.
  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check_eq("rst_strobes", 32'(w_obs), 32'h0);
    check_eq("rst_run", 32'(o_run), 32'h0);
    check_eq("rst_illegal", 32'(o_illegal), 32'h0);
    m_mode     = MIdle;
    m_q.delete();
    m_illegal  = 1'b0;
    halt_cnt   = 0;
    ir_pending = 1'b0;
    @(negedge i_clk);
    check_eq("rst_hold", 32'({w_obs, o_run, o_illegal}), 32'h0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    i_rst_n       = 1'b0;
    i_stop        = 1'b0;
    i_ir          = 32'h0;
    m_mode        = MIdle;
    m_illegal     = 1'b0;
    halt_cnt      = 0;
    ir_pending    = 1'b0;
    did_mid_reset = 1'b0;
    forced_ir = '{32'hB080_0000, 32'hB880_0000, 32'h1989_0000, 32'h1989_0000,
                  32'hF800_0000, 32'hD800_0000};
    repeat (2) @(negedge i_clk);
    check_eq("reset_strobes", 32'(w_obs), 32'h0);
    check_eq("reset_run", 32'(o_run), 32'h0);
    check_eq("reset_illegal", 32'(o_illegal), 32'h0);
    i_rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      i_stop = ($urandom_range(0, 3) == 0);
      advance_model();
      @(posedge i_clk);
      #1;
      if (ir_pending) begin
        i_ir       = next_ir;
        ir_pending = 1'b0;
      end
      @(negedge i_clk);
      compare_cycle();
      if (!did_mid_reset && m_mode == MRun && m_alu && m_q.size() == 2) begin
        did_mid_reset = 1'b1;
        do_reset();
      end else if ((m_mode == MHalt && halt_cnt >= 20) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
